// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_SETUP = 2'd0,
    ST_IDLE       = 2'd1,
    ST_BUSY       = 2'd2,
    ST_RELEASE    = 2'd3
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_pick2
  import flash_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;

  // Winner selection; id follows the req bit index (0 = CPU, 1 = DBG).
  always_comb begin
    gnt_id = REQ_CPU;
    if (req == 2'b11) begin
      gnt_id = ~last;
    end else if (req[REQ_DBG]) begin
      gnt_id = REQ_DBG;
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Arbitrates single-byte reads between the CPU fetch path and the debug-SPI
// path onto one QSPI flash reader, with a busy timeout and setup gating.
//
//   state         | meaning
//   --------------+-----------------------------------------------------
//   WAIT_SETUP    | flash reader not ready; no grants
//   IDLE          | ready; grant on the first edge with any request
//   BUSY          | read in flight; waiting for data, timeout or setup loss
//   RELEASE       | one-cycle gap so the finished owner's stale req is not regranted
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              cpu_done,
  output logic              dbg_done,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_do_read,
  input  logic              flash_setup_done,
  input  logic              flash_data_ready,
  input  logic [7:0]        flash_data
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic             r_last;

  logic [1:0]       w_req;
  logic             w_gnt_valid;
  logic             w_gnt_id;

  assign w_req = {dbg_req, cpu_req};

  rr_pick2 u_pick (
    .req       (w_req),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // Arbiter FSM with registered command and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_WAIT_SETUP;
      r_cnt         <= '0;
      r_owner       <= REQ_CPU;
      r_last        <= REQ_DBG;
      flash_addr    <= '0;
      flash_do_read <= 1'b0;
      cpu_done      <= 1'b0;
      dbg_done      <= 1'b0;
      rsp_data      <= 8'h00;
      rsp_err       <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (r_state)
        ST_WAIT_SETUP: begin
          if (flash_setup_done) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!flash_setup_done) begin
            r_state <= ST_WAIT_SETUP;
          end else if (w_gnt_valid) begin
            flash_addr    <= (w_gnt_id == REQ_DBG) ? dbg_addr : cpu_addr;
            flash_do_read <= 1'b1;
            r_owner       <= w_gnt_id;
            r_last        <= w_gnt_id;
            r_cnt         <= '0;
            r_state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Setup loss aborts regardless of data; data beats the timeout.
          if (!flash_setup_done) begin
            rsp_data      <= 8'hFF;
            rsp_err       <= 1'b1;
            cpu_done      <= (r_owner == REQ_CPU);
            dbg_done      <= (r_owner == REQ_DBG);
            flash_do_read <= 1'b0;
            r_state       <= ST_WAIT_SETUP;
          end else if (flash_data_ready) begin
            rsp_data      <= flash_data;
            rsp_err       <= 1'b0;
            cpu_done      <= (r_owner == REQ_CPU);
            dbg_done      <= (r_owner == REQ_DBG);
            flash_do_read <= 1'b0;
            r_state       <= ST_RELEASE;
          end else if (r_cnt == CNT_LAST) begin
            rsp_data      <= 8'hFF;
            rsp_err       <= 1'b1;
            cpu_done      <= (r_owner == REQ_CPU);
            dbg_done      <= (r_owner == REQ_DBG);
            flash_do_read <= 1'b0;
            r_state       <= ST_RELEASE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          r_state <= flash_setup_done ? ST_IDLE : ST_WAIT_SETUP;
        end
        default: begin
          r_state <= ST_WAIT_SETUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: directed scenarios plus
// randomized transactions against a transaction-level reference.
module tb_flash_read_arbiter;

  localparam int AW  = 24;
  localparam int T   = 16;
  localparam int CPU = 0;
  localparam int DBG = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, dbg_req;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic          cpu_done, dbg_done;
  logic [7:0]    rsp_data;
  logic          rsp_err;
  logic [AW-1:0] flash_addr;
  logic          flash_do_read;
  logic          flash_setup_done, flash_data_ready;
  logic [7:0]    flash_data;

  int n_checks = 0;
  int n_fail   = 0;
  int last_id  = DBG;

  flash_read_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_req          (cpu_req),
    .cpu_addr         (cpu_addr),
    .dbg_req          (dbg_req),
    .dbg_addr         (dbg_addr),
    .cpu_done         (cpu_done),
    .dbg_done         (dbg_done),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .flash_addr       (flash_addr),
    .flash_do_read    (flash_do_read),
    .flash_setup_done (flash_setup_done),
    .flash_data_ready (flash_data_ready),
    .flash_data       (flash_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference arbitration rule: lone requester wins, a tie goes to the other one.
  function automatic int rr_ref(input logic c, input logic d, input int last);
    if (c && d) return 1 - last;
    return c ? CPU : DBG;
  endfunction

  // One transaction: wait for the grant, reply after lat BUSY cycles
  // (lat >= T means never reply), check done/data/err and the release cycle.
  task automatic do_txn(input int lat, input logic [7:0] d, input bit drop_mid,
                        input bit drop_at_done, output int got_id, output int wait_n);
    int            exp_id;
    int            done_at;
    bit            exp_err;
    bit            granted;
    logic [AW-1:0] exp_addr;
    exp_id  = rr_ref(cpu_req, dbg_req, last_id);
    granted = 1'b0;
    wait_n  = 0;
    got_id  = -1;
    while (!granted && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
      if (flash_do_read === 1'b1) granted = 1'b1;
    end
    chk_eq("grant_seen", 32'(granted), 32'd1);
    if (!granted) return;
    last_id  = exp_id;
    exp_addr = (exp_id == CPU) ? cpu_addr : dbg_addr;
    chk_eq("grant_addr", 32'(flash_addr), 32'(exp_addr));
    if (lat <= T - 1) begin
      done_at = lat + 1;
      exp_err = 1'b0;
    end else begin
      done_at = T;
      exp_err = 1'b1;
    end
    for (int c = 0; c < done_at; c++) begin
      flash_data_ready = (c == lat);
      flash_data       = (c == lat) ? d : 8'($urandom);
      if (drop_mid && c == done_at / 2) begin
        if (exp_id == CPU) cpu_req = 1'b0;
        else dbg_req = 1'b0;
      end
      @(negedge clk);
      flash_data_ready = 1'b0;
      if (c + 1 < done_at) begin
        chk_eq("busy_ctl", 32'({flash_do_read, cpu_done, dbg_done}), 32'b100);
        chk_eq("busy_addr", 32'(flash_addr), 32'(exp_addr));
      end
    end
    chk_eq("done_owner", 32'({cpu_done, dbg_done}), (exp_id == CPU) ? 32'b10 : 32'b01);
    chk_eq("done_do_read", 32'(flash_do_read), 32'd0);
    chk_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk_eq("rsp_data", 32'(rsp_data), exp_err ? 32'hFF : 32'(d));
    got_id = cpu_done ? CPU : (dbg_done ? DBG : -1);
    if (drop_at_done) begin
      if (exp_id == CPU) cpu_req = 1'b0;
      else dbg_req = 1'b0;
    end
    @(negedge clk);
    chk_eq("release", 32'({flash_do_read, cpu_done, dbg_done}), 32'd0);
  endtask

  task automatic apply_reset(input logic setup);
    rst = 1'b0;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    flash_data_ready = 1'b0;
    flash_setup_done = setup;
    repeat (2) @(negedge clk);
    last_id = DBG;
    rst = 1'b1;
  endtask

  initial begin
    int got, wn;
    bit seen;
    logic [7:0] d;
    int lat;
    rst = 1'b0;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    cpu_addr = '0;
    dbg_addr = '0;
    flash_setup_done = 1'b0;
    flash_data_ready = 1'b0;
    flash_data = 8'h00;
    #1;
    chk_eq("rst_ctl", 32'({flash_do_read, cpu_done, dbg_done, rsp_err}), 32'd0);
    chk_eq("rst_addr", 32'(flash_addr), 32'd0);
    chk_eq("rst_data", 32'(rsp_data), 32'd0);

    // Setup gating, with stray data_ready that must be ignored.
    apply_reset(1'b0);
    cpu_addr = 24'h123456;
    dbg_addr = 24'h654321;
    cpu_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      flash_data_ready = 1'($urandom_range(0, 1));
      flash_data = 8'($urandom);
      @(negedge clk);
      if (flash_do_read || cpu_done || dbg_done) seen = 1'b1;
    end
    flash_data_ready = 1'b0;
    chk_eq("gate_no_read", 32'(seen), 32'd0);
    flash_setup_done = 1'b1;
    do_txn(3, 8'h5A, 1'b0, 1'b1, got, wn);
    chk_eq("gate_grant_lat", 32'(wn <= 2), 32'd1);
    chk_eq("gate_owner", 32'(got), CPU);

    // Tie from reset: CPU first, then DBG.
    apply_reset(1'b1);
    cpu_addr = 24'h000100;
    dbg_addr = 24'h0A0000;
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    do_txn(2, 8'h11, 1'b0, 1'b1, got, wn);
    chk_eq("tie_first", 32'(got), CPU);
    do_txn(4, 8'h22, 1'b0, 1'b1, got, wn);
    chk_eq("tie_second", 32'(got), DBG);

    // Fairness with both held continuously.
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_txn($urandom_range(0, 5), 8'($urandom), 1'b0, 1'b0, got, wn);
      chk_eq("fair_seq", 32'(got), (i % 2 == 0) ? CPU : DBG);
    end

    // Timeout on a DBG read that is never answered.
    cpu_req = 1'b0;
    dbg_req = 1'b1;
    do_txn(1000, 8'h00, 1'b0, 1'b1, got, wn);
    chk_eq("tmo_owner", 32'(got), DBG);

    // Setup loss mid-BUSY.
    cpu_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (flash_do_read) seen = 1'b1;
    end
    chk_eq("sl_grant", 32'(seen), 32'd1);
    last_id = CPU;
    repeat (3) @(negedge clk);
    dbg_req = 1'b1;
    flash_setup_done = 1'b0;
    @(negedge clk);
    chk_eq("sl_done", 32'({cpu_done, dbg_done}), 32'b10);
    chk_eq("sl_err", 32'(rsp_err), 32'd1);
    chk_eq("sl_data", 32'(rsp_data), 32'hFF);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (flash_do_read || cpu_done || dbg_done) seen = 1'b1;
    end
    chk_eq("sl_no_grant", 32'(seen), 32'd0);
    flash_setup_done = 1'b1;
    do_txn(1, 8'h3C, 1'b0, 1'b1, got, wn);
    chk_eq("sl_regrant", 32'(got), DBG);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      cpu_req = 1'($urandom_range(0, 1));
      dbg_req = 1'($urandom_range(0, 1));
      if (!cpu_req && !dbg_req) begin
        if ($urandom_range(0, 1) == 0) cpu_req = 1'b1;
        else dbg_req = 1'b1;
      end
      cpu_addr = AW'($urandom);
      dbg_addr = AW'($urandom);
      lat = $urandom_range(0, 19);
      d = 8'($urandom);
      do_txn(lat, d, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), got, wn);
    end

    // Asynchronous reset mid-BUSY.
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (flash_do_read) seen = 1'b1;
    end
    chk_eq("ar_grant", 32'(seen), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_eq("ar_do_read", 32'(flash_do_read), 32'd0);
    chk_eq("ar_done_now", 32'({cpu_done, dbg_done}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_done || dbg_done || flash_do_read) seen = 1'b1;
    end
    chk_eq("ar_quiet", 32'(seen), 32'd0);
    last_id = DBG;
    rst = 1'b1;
    do_txn(2, 8'h77, 1'b0, 1'b1, got, wn);
    chk_eq("ar_cpu_first", 32'(got), CPU);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
